i2s_tx_ctrl: RTL and testbench

I2S_TX_CTRL -- requirements
Module: i2s_tx_ctrl

---
 rtl/audio_pkg.sv | 22 ++
 rtl/bclk_frac_div.sv | 52 +++++
 rtl/i2s_tx_ctrl.sv | 152 +++++++++++++++
 tb/tb_i2s_tx_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio constants and types for the I2S transmitter.
package audio_pkg;

    localparam int unsigned BCLK_LOW_CYC  = 16;
    localparam int unsigned BCLK_BASE_DIV = 31;

    // BCLK period per phase index: 31, 31, 31, 32 clk (average 31.25 clk).
    localparam logic [3:0][5:0] BCLK_FRAC_PATTERN = {
        6'(BCLK_BASE_DIV + 1), 6'(BCLK_BASE_DIV), 6'(BCLK_BASE_DIV), 6'(BCLK_BASE_DIV)
    };

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StStop
    } i2s_state_t;

    function automatic logic [5:0] bclk_period(input logic [1:0] idx);
        return BCLK_FRAC_PATTERN[idx];
    endfunction

endpackage

// File: rtl/bclk_frac_div.sv
// Fractional BCLK divider: 31/31/31/32 clk periods, low for the first 16 clk of each.
module bclk_frac_div
    import audio_pkg::*;
(
    input  logic clk,
    input  logic reset_n,
    input  logic run,
    output logic bclk,
    output logic fall_stb,
    output logic rise_stb
);

    logic [5:0] ph_q, ph_d;
    logic [1:0] idx_q, idx_d;
    logic       bclk_q, bclk_d;
    logic       wrap;

    // Phase counter advance; parked at zero (bclk low) whenever not running.
    always_comb begin
        wrap   = run && (ph_q == bclk_period(idx_q) - 6'd1);
        ph_d   = '0;
        idx_d  = '0;
        if (run) begin
            if (wrap) begin
                ph_d  = '0;
                idx_d = idx_q + 2'd1;
            end else begin
                ph_d  = ph_q + 6'd1;
                idx_d = idx_q;
            end
        end
        bclk_d = run && (ph_d >= 6'(BCLK_LOW_CYC));
    end

    // Divider state registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ph_q   <= '0;
            idx_q  <= '0;
            bclk_q <= 1'b0;
        end else begin
            ph_q   <= ph_d;
            idx_q  <= idx_d;
            bclk_q <= bclk_d;
        end
    end

    assign bclk     = bclk_q;
    assign fall_stb = wrap;
    assign rise_stb = run && (ph_q == 6'(BCLK_LOW_CYC - 1));

endmodule

// File: rtl/i2s_tx_ctrl.sv
// I2S stereo transmitter with one-entry holding register and underrun flag.
// Build option: define I2S_TX_HOLD_LAST_EN to repeat the last pair on underrun
// instead of sending silence.
module i2s_tx_ctrl
    import audio_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                en,
    input  logic                s_valid,
    input  logic [SAMPLE_W-1:0] s_left,
    input  logic [SAMPLE_W-1:0] s_right,
    output logic                s_ready,
    output logic                bclk,
    output logic                lrclk,
    output logic                sdata,
    output logic                busy,
    output logic                underrun
);

    localparam int unsigned FRAME_W = 2 * SAMPLE_W;
    localparam int unsigned CNT_W   = $clog2(FRAME_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);
    localparam logic [CNT_W-1:0] WS_START = CNT_W'(SAMPLE_W - 1);
    localparam logic [CNT_W-1:0] WS_END   = CNT_W'(FRAME_W - 2);

    i2s_state_t         state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0] hold_q, hold_d;
    logic               hold_full_q, hold_full_d;
    logic [FRAME_W-1:0] shift_q, shift_d;
    logic               underrun_q, underrun_d;
    logic [FRAME_W-1:0] fill;

    logic run, fall_stb, rise_stb, accept, boundary, stop_now, load;
    logic unused_rise_stb;

    assign run             = (state_q != StIdle);
    assign unused_rise_stb = rise_stb;

    bclk_frac_div u_div (
        .clk      (clk),
        .reset_n  (reset_n),
        .run      (run),
        .bclk     (bclk),
        .fall_stb (fall_stb),
        .rise_stb (rise_stb)
    );

`ifdef I2S_TX_HOLD_LAST_EN
    logic [FRAME_W-1:0] last_q, last_d;
    assign fill = last_q;
`else
    assign fill = '0;
`endif

    assign accept   = s_valid && !hold_full_q;
    assign boundary = fall_stb && (bit_cnt_q == LAST_BIT);
    // A stop request only takes effect at a frame boundary; that boundary loads nothing.
    assign stop_now = boundary && (state_q == StStop) && !en;
    assign load     = boundary && !stop_now;

    // FSM next state, serialiser and holding-register bookkeeping.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        shift_d     = shift_q;
        underrun_d  = 1'b0;
`ifdef I2S_TX_HOLD_LAST_EN
        last_d      = last_q;
`endif

        unique case (state_q)
            StIdle: begin
                if (en) begin
                    state_d   = StRun;
                    bit_cnt_d = LAST_BIT;
                    shift_d   = '0;
                end
            end
            StRun:  if (!en) state_d = StStop;
            StStop: begin
                if (en) state_d = StRun;
                else if (boundary) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (fall_stb) begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            shift_d   = shift_q << 1;
        end

        if (load) begin
            if (hold_full_q) begin
                shift_d     = hold_q;
                hold_full_d = 1'b0;
            end else begin
                shift_d    = fill;
                underrun_d = 1'b1;
            end
`ifdef I2S_TX_HOLD_LAST_EN
            last_d = shift_d;
`endif
        end

        if (stop_now) shift_d = '0;

        // Accept only happens with hold empty, so it never races a hold->shift load.
        if (accept) begin
            hold_d      = {s_left, s_right};
            hold_full_d = 1'b1;
        end
    end

    // State registers; reset abandons any frame and discards held data.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            shift_q     <= '0;
            underrun_q  <= 1'b0;
`ifdef I2S_TX_HOLD_LAST_EN
            last_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            shift_q     <= shift_d;
            underrun_q  <= underrun_d;
`ifdef I2S_TX_HOLD_LAST_EN
            last_q      <= last_d;
`endif
        end
    end

    assign s_ready  = !hold_full_q;
    assign busy     = run;
    assign underrun = underrun_q;
    assign sdata    = run && shift_q[FRAME_W-1];
    // Word select leads the MSB of each channel by one BCLK.
    assign lrclk    = run && (bit_cnt_q >= WS_START) && (bit_cnt_q <= WS_END);

endmodule

// File: tb/tb_i2s_tx_ctrl.sv
// Scoreboard bench for i2s_tx_ctrl: driver pushes expected frames, monitor decodes I2S.
module tb_i2s_tx_ctrl;

    localparam int W  = 16;
    localparam int FW = 2 * W;
    localparam int N  = 10;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic         en = 1'b0;
    logic         s_valid = 1'b0;
    logic [W-1:0] s_left = '0;
    logic [W-1:0] s_right = '0;
    logic         s_ready, bclk, lrclk, sdata, busy, underrun;

    i2s_tx_ctrl #(.SAMPLE_W(W)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (en),
        .s_valid  (s_valid),
        .s_left   (s_left),
        .s_right  (s_right),
        .s_ready  (s_ready),
        .bclk     (bclk),
        .lrclk    (lrclk),
        .sdata    (sdata),
        .busy     (busy),
        .underrun (underrun)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    logic [FW-1:0] exp_q[$];
    logic [FW-1:0] model_last = '0;
    int exp_underruns = 0;
    int seen_underruns = 0;

    task automatic check(input string name, input longint act, input longint req);
        vectors++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Value the transmitter must send for a frame with no fresh data.
    function automatic logic [FW-1:0] underrun_fill();
`ifdef I2S_TX_HOLD_LAST_EN
        return model_last;
`else
        return '0;
`endif
    endfunction

    // ---------------- monitor: timing checks and serial decode ----------------
    longint cyc = 0, t_last = 0, t_lr = 0;
    int r = 0, fall_idx = 0;
    bit in_run = 0, have_lr = 0, prev_bclk = 0, prev_lr = 0;
    logic [FW-1:0] frame = '0;

    always @(negedge clk) begin
        cyc++;
        if (!busy) begin
            in_run = 0;
        end else begin
            if (!in_run) begin
                in_run = 1; t_last = cyc; r = 0; fall_idx = 0; have_lr = 0;
            end
            if (prev_bclk && !bclk) begin
                check("bclk_period", cyc - t_last, (fall_idx % 4 == 3) ? 32 : 31);
                t_last = cyc;
                fall_idx++;
            end
            if (!prev_bclk && bclk) begin
                if (r > 0) begin
                    int b;
                    b = (r - 1) % FW;
                    frame[FW-1-b] = sdata;
                    check("lrclk_bit", lrclk, (b >= W - 1 && b <= FW - 2) ? 1 : 0);
                    if (b == FW - 1) begin
                        if (exp_q.size() == 0) begin
                            vectors++; miscompares++;
                            $display("FAIL frame_unexpected: got 0x%0h, expected no frame", frame);
                        end else begin
                            logic [FW-1:0] e;
                            e = exp_q.pop_front();
                            check("frame_left", frame[FW-1:W], e[FW-1:W]);
                            check("frame_right", frame[W-1:0], e[W-1:0]);
                        end
                    end
                end
                r++;
            end
            if (!prev_lr && lrclk) begin
                if (have_lr) check("frame_len", cyc - t_lr, 1000);
                have_lr = 1;
                t_lr = cyc;
            end
        end
        if (underrun) seen_underruns++;
        prev_bclk = bclk;
        prev_lr = lrclk;
    end

    // ---------------- driver helpers ----------------
    task automatic offer(input logic [W-1:0] l, input logic [W-1:0] rr);
        s_valid = 1'b1; s_left = l; s_right = rr;
        for (int k = 0; k < 3000; k++) begin
            if (s_ready) break;
            @(negedge clk);
        end
        if (!s_ready) check("offer_timeout", 0, 1);
        @(posedge clk);
        #1 s_valid = 1'b0;
        exp_q.push_back({l, rr});
        model_last = {l, rr};
    endtask

    task automatic wait_ready();
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (s_ready) break;
        end
        if (!s_ready) check("ready_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (!busy) break;
        end
        if (busy) check("idle_timeout", 0, 1);
    endtask

    task automatic skip_frame();
        exp_q.push_back(underrun_fill());
        exp_underruns++;
        repeat (1010) @(posedge clk);
    endtask

    task automatic check_all_low(input string tag);
        check({tag, "_bclk"}, bclk, 0);
        check({tag, "_lrclk"}, lrclk, 0);
        check({tag, "_sdata"}, sdata, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_underrun"}, underrun, 0);
        check({tag, "_s_ready"}, s_ready, 1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        realtime t0;
        int quiet_bad;
        bit skip;

        repeat (3) @(posedge clk);
        #1 check_all_low("reset");
        reset_n = 1'b1;

        // Pair preloaded before enable so the first frame carries data.
        offer(16'hA5C3, 16'h0F0F);
        @(posedge clk);
        #1 en = 1'b1;

        for (int i = 1; i < N; i++) begin
            wait_ready();
            skip = (i == 6) || (i >= 7 && i < N - 1 && $urandom_range(0, 2) == 0);
            if (skip) begin
                skip_frame();
            end else if (i < 3) begin
                offer(16'hA5C3, 16'h0F0F);
            end else begin
                offer(W'($urandom), W'($urandom));
            end
            if (i == 4) begin
                // Drop enable near bit 5 and bring it back near bit 20.
                repeat (170) @(posedge clk);
                #1 en = 1'b0;
                repeat (235) @(posedge clk);
                check("busy_in_stop", busy, 1);
                repeat (235) @(posedge clk);
                check("busy_in_stop_late", busy, 1);
                #1 en = 1'b1;
            end
        end

        // Final stop: the frame in progress completes, then idle at the next boundary.
        wait_ready();
        t0 = $realtime;
        repeat (170) @(posedge clk);
        #1 en = 1'b0;
        repeat (400) @(posedge clk);
        check("busy_final_stop", busy, 1);
        wait_idle();
        check("stop_to_idle_clk", longint'(($realtime - t0) / 10.0), 1000);
        check("queue_after_stream", exp_q.size(), 0);

        // Mid-frame reset with a pair held.
        offer(16'h1234, 16'h5678);
        void'(exp_q.pop_back());
        @(posedge clk);
        #1 en = 1'b1;
        wait_ready();
        offer(16'hDEAD, 16'hBEEF);
        void'(exp_q.pop_back());
        check("hold_full_before_reset", s_ready, 0);
        repeat (330) @(posedge clk);
        #2 reset_n = 1'b0;
        en = 1'b0;
        #1 check_all_low("midreset");
        @(posedge clk);
        #1 reset_n = 1'b1;
        model_last = '0;
        quiet_bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (bclk || lrclk || sdata || busy) quiet_bad++;
        end
        check("quiet_after_reset", quiet_bad, 0);
        check("held_discarded", s_ready, 1);

        // Restart with no data: first frame underruns, then fresh pair.
        #1 en = 1'b1;
        exp_q.push_back(underrun_fill());
        exp_underruns++;
        repeat (40) @(posedge clk);
        offer(W'($urandom), W'($urandom));
        wait_ready();
        repeat (170) @(posedge clk);
        #1 en = 1'b0;
        wait_idle();
        repeat (5) @(posedge clk);

        check("queue_drained", exp_q.size(), 0);
        check("underrun_count", seen_underruns, exp_underruns);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
